async_receiver: RTL and testbench
=================================

// Module: async_receiver
// PURPOSE
//  Serial frame receiver, one bit per Clk: start(0), DATA_BITS data LSB first, odd parity, stop.
//  Sits at the far end of the serial line D driven by the team's transmitter on the same Clk (no oversampling).
//  Recovers the word, checks parity and stop bit, holds the word in an output register with a Valid/Ack handshake.
// PARAMETERS
//  DATA_BITS   5   data bits per frame (1..14); frame length = DATA_BITS+3 bits
//  STOP_LEVEL  0   required line level of the stop bit
// PORTS
//  Clk        in   1          clock; line sampled on rising edge
//  Rst_n      in   1          asynchronous reset, active-low
//  D          in   1          serial line; idle level 1
//  Ack        in   1          consumer has taken Dout; clears Valid
//  Dout       out  DATA_BITS  last good received word
//  Valid      out  1          Dout holds an unacknowledged word (level)
//  ParityErr  out  1          1-cycle pulse: frame had bad parity, discarded
//  FrameErr   out  1          1-cycle pulse: stop bit != STOP_LEVEL, discarded
//  Overrun    out  1          1-cycle pulse: good frame dropped because Valid=1 and no Ack
//  Busy       out  1          1 while in DATA/PARITY/STOP
// BEHAVIOUR
//  Reset (Rst_n=0, async): state=IDLE, bit counter=0, shift reg=0; Dout=0, Valid=0, all pulses 0, Busy=0.
//  FSM, one transition per rising Clk edge; s = sampled line value:
//   IDLE:   s==0 -> DATA, cnt=0 (start bit); s==1 -> stay.
//   DATA:   sh[cnt]=s, par^=s; cnt==DATA_BITS-1 -> PARITY else cnt++.
//   PARITY: perr = (s != ~par), i.e. data+parity bits must have an odd count of ones -> STOP.
//   STOP:   ferr = (s != STOP_LEVEL); -> IDLE always. The stop sample is never taken as a start bit.
//  Start of next frame is recognized at the first edge in IDLE, so back-to-back frames
//   (start immediately after stop, no idle bit) are received without loss.
//  par is cleared when the start bit is taken.
//  Latency: start sampled at edge E0 -> frame result registered at edge E0+DATA_BITS+2.
//   Valid/Dout/pulses are visible after that edge.
//  Result at the STOP edge:
//   - ferr=1                 -> FrameErr pulse; Dout/Valid unchanged. ParityErr also pulses if perr=1.
//   - perr=1, ferr=0         -> ParityErr pulse; Dout/Valid unchanged.
//   - good, Valid=0 or Ack=1 -> Dout=sh, Valid=1.
//   - good, Valid=1, Ack=0   -> new word dropped, Dout kept, Overrun pulse.
//  Ack with Valid=1 and no good frame that edge -> Valid=0; Dout keeps its value.
//  Ack with Valid=0 has no effect.
//  Line going to 1 mid-frame (transmitter stopped) is not detected early; it is sampled as data.
//   Typically it ends in ParityErr or FrameErr.
//  Reset mid-frame: everything returns to reset values immediately; the partial frame is lost.
//   The next start bit after release is received normally.
//  Pulses are exactly one cycle wide; Busy=1 from the edge after the start sample through the STOP edge.
// CONFIGURATION
//  RX_SYNC_EN defined: D passes through 2 flops (reset to 1) before the FSM.
//   All latencies grow by 2 cycles; use when D comes from another clock domain.
//  RX_SYNC_EN undefined: the FSM samples D directly, latency as above.
// TESTING (DATA_BITS=5, STOP_LEVEL=0, RX_SYNC_EN off unless stated)
//  1 Line samples 1,1,0,0,1,1,0,1,0,0 (word 5'h16, parity 0) -> Valid=1, Dout=5'h16 after the 10th edge, no error pulses.
//  2 Same frame, parity bit 1 -> ParityErr pulse 1 cycle, Valid stays 0, Dout stays 0.
//  3 Same frame, stop bit 1 -> FrameErr pulse, Valid 0; the following idle 1s cause no start.
//  4 5'h16 frame then 5'h09 frame (0,1,0,0,1,0,1,0) back-to-back, Ack pulsed between them
//    -> Dout=5'h16 then 5'h09, two Valid rises.
//  5 As 4 but no Ack -> Dout stays 5'h16, Valid stays 1, Overrun pulses at the end of the 2nd frame.
//  6 Rst_n low after 3 data bits -> outputs at reset values with no clock; a full 5'h16 frame after release is received.
//    Repeat test 1 with RX_SYNC_EN -> Valid 2 cycles later.

Source files
------------

// File: rtl/async_receiver.sv
// async_receiver: serial frame receiver (start, DATA_BITS data LSB first, odd parity, stop), one bit per clock.
// Ports: Clk/Rst_n (async active-low) clock and reset; D serial line (idle 1); Ack consumer handshake;
//        Dout last good word; Valid unacknowledged word held; ParityErr/FrameErr/Overrun one-cycle pulses;
//        Busy high while a frame is in progress.
// Build option RX_SYNC_EN: passes D through two flops (reset to 1) before the FSM, adding 2 cycles of latency.
module async_receiver #(
    parameter int   DATA_BITS  = 5,
    parameter logic STOP_LEVEL = 1'b0
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 D,
    input  logic                 Ack,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 Valid,
    output logic                 ParityErr,
    output logic                 FrameErr,
    output logic                 Overrun,
    output logic                 Busy
);
    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 s;
    logic                 good;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], D};
    end
    assign s = sync_q[1];
`else
    assign s = D;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sh_q         <= '0;
            par_q        <= 1'b0;
            perr_q       <= 1'b0;
            dout_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            par_q        <= par_d;
            perr_q       <= perr_d;
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        par_d   = par_q;
        perr_d  = perr_q;
        case (state_q)
            IDLE: begin
                state_d = s ? IDLE : DATA;
                cnt_d   = s ? cnt_q : '0;
                par_d   = s ? par_q : 1'b0;
            end
            DATA: begin
                sh_d[cnt_q] = s;
                par_d       = par_q ^ s;
                state_d     = (cnt_q == CW'(DATA_BITS - 1)) ? PARITY : DATA;
                cnt_d       = (cnt_q == CW'(DATA_BITS - 1)) ? cnt_q : cnt_q + 1'b1;
            end
            PARITY: begin
                // Data plus parity must hold an odd number of ones.
                perr_d  = (s != ~par_q);
                state_d = STOP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        good         = (state_q == STOP) && !perr_q && (s == STOP_LEVEL);
        dout_d       = (good && (!valid_q || Ack)) ? sh_q : dout_q;
        valid_d      = good ? 1'b1 : (Ack ? 1'b0 : valid_q);
        overrun_d    = good && valid_q && !Ack;
        parity_err_d = (state_q == STOP) && perr_q;
        frame_err_d  = (state_q == STOP) && (s != STOP_LEVEL);
        Dout         = dout_q;
        Valid        = valid_q;
        ParityErr    = parity_err_q;
        FrameErr     = frame_err_q;
        Overrun      = overrun_q;
        Busy         = (state_q != IDLE);
    end
endmodule

// File: tb/tb_async_receiver.sv
// tb_async_receiver: frame-level reference model bench for async_receiver with directed and random frames.
module tb_async_receiver;
    localparam int   DB = 5;
    localparam logic SL = 1'b0;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          D = 1'b1;
    logic          Ack = 1'b0;
    logic [DB-1:0] Dout;
    logic          Valid, ParityErr, FrameErr, Overrun, Busy;

    int tests = 0;
    int fails = 0;

    logic [DB-1:0] m_dout = '0;
    logic          m_valid = 1'b0;

    always #5 Clk = ~Clk;

    async_receiver #(.DATA_BITS(DB), .STOP_LEVEL(SL)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .D(D), .Ack(Ack), .Dout(Dout), .Valid(Valid),
        .ParityErr(ParityErr), .FrameErr(FrameErr), .Overrun(Overrun), .Busy(Busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One line bit: drive, clock, then compare every output with the frame-level model.
    task automatic cycle(input logic d, input logic ack, input logic is_stop, input logic good,
                         input logic [DB-1:0] word, input logic pe, input logic fe, input logic busy);
        logic ov;
        D   = d;
        Ack = ack;
        @(posedge Clk);
        #1;
        ov = 1'b0;
        if (is_stop && good) begin
            if (m_valid && !ack) ov = 1'b1;
            else begin
                m_dout  = word;
                m_valid = 1'b1;
            end
        end else if (ack) m_valid = 1'b0;
        check("valid", 32'(Valid), 32'(m_valid));
        check("dout", 32'(Dout), 32'(m_dout));
        check("parity_err", 32'(ParityErr), 32'(is_stop && pe));
        check("frame_err", 32'(FrameErr), 32'(is_stop && fe));
        check("overrun", 32'(Overrun), 32'(ov));
        check("busy", 32'(Busy), 32'(busy));
    endtask

    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) cycle(1'b1, ack, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // ack_pat bit i drives Ack during frame bit i (0 = start, DB+2 = stop).
    task automatic send_frame(input logic [DB-1:0] word, input logic bad_par, input logic bad_stop,
                              input logic [31:0] ack_pat);
        logic [DB+2:0] bits;
        logic          good;
        good = !bad_par && !bad_stop;
        bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) bits[i+1] = word[i];
        bits[DB+1] = ~(^word) ^ bad_par;
        bits[DB+2] = SL ^ bad_stop;
        for (int i = 0; i <= DB + 2; i++)
            cycle(bits[i], ack_pat[i], i == DB + 2, good, word, bad_par, bad_stop, i != DB + 2);
    endtask

    initial begin
        #3;
        check("rst_valid", 32'(Valid), 32'd0);
        check("rst_dout", 32'(Dout), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_pulses", 32'({ParityErr, FrameErr, Overrun}), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        idle(2, 1'b0);
        // Good 5'h16 frame, then parity error, then stop error followed by idle ones.
        send_frame(5'h16, 1'b0, 1'b0, 32'd0);
        idle(1, 1'b1);
        send_frame(5'h16, 1'b1, 1'b0, 32'd0);
        send_frame(5'h16, 1'b0, 1'b1, 32'd0);
        idle(3, 1'b0);
        // Back-to-back with Ack during the second frame's start bit.
        send_frame(5'h16, 1'b0, 1'b0, 32'd0);
        send_frame(5'h09, 1'b0, 1'b0, 32'd1);
        idle(1, 1'b1);
        // Back-to-back without Ack: the second word is dropped.
        send_frame(5'h16, 1'b0, 1'b0, 32'd0);
        send_frame(5'h09, 1'b0, 1'b0, 32'd0);
        idle(1, 1'b1);
        // Reset after three data bits, checked before any clock edge.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        Rst_n = 1'b0;
        D = 1'b1;
        #2;
        check("mid_rst_busy", 32'(Busy), 32'd0);
        check("mid_rst_valid", 32'(Valid), 32'd0);
        check("mid_rst_dout", 32'(Dout), 32'd0);
        m_valid = 1'b0;
        m_dout  = '0;
        @(negedge Clk);
        Rst_n = 1'b1;
        idle(1, 1'b0);
        send_frame(5'h16, 1'b0, 1'b0, 32'd0);
        // Random frames, errors, gaps and sparse Ack.
        for (int f = 0; f < 300; f++) begin
            send_frame(DB'($urandom), ($urandom % 6) == 0, ($urandom % 6) == 0,
                       $urandom & $urandom & $urandom);
            idle($urandom_range(0, 2), ($urandom % 3) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
